ntt_sequencer: RTL and testbench

Parametrised schedule generator for the NTT core array. It replaces the hard-coded three-stage controller with a generic stage walker that supports any transform length, core count and pipeline depth. It runs forward and inverse transforms, and the inverse adds a final scaling pass. Between stages it inserts pipeline-drain bubbles so the array never hits a read-after-write hazard. It drives the shared read addresses and stage parameters into the cores, and a delayed write-back copy into the router.

---
 rtl/ntt_sequencer.sv | 154 +++++++++++++++
 tb/tb_ntt_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_sequencer.sv
// Stage/address schedule generator for the NTT core array: walks forward or inverse stages,
// inserts drain bubbles between stages and emits a delayed write-back copy of the issue stream.
module ntt_sequencer #(
    parameter int unsigned  LOG_N          = 12,
    parameter int unsigned  LOG_CORE_COUNT = 5,
    parameter int unsigned  PIPE_STAGES    = 10,
    localparam int unsigned ADDR_W         = LOG_N - 1 - LOG_CORE_COUNT,
    localparam int unsigned LW             = $clog2(LOG_N)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_inverse,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_issue_valid,
    output logic [1:0]        o_phase,
    output logic [LW-1:0]     o_log_m,
    output logic [LW-1:0]     o_log_t,
    output logic [ADDR_W-1:0] o_even_addr,
    output logic [ADDR_W-1:0] o_odd_addr,
    output logic              o_wb_valid,
    output logic [1:0]        o_wb_phase,
    output logic [LW-1:0]     o_wb_log_m,
    output logic [LW-1:0]     o_wb_log_t,
    output logic [ADDR_W-1:0] o_wb_even_addr,
    output logic [ADDR_W-1:0] o_wb_odd_addr
);

    localparam int unsigned D  = 1 << ADDR_W;
    localparam int unsigned SW = $clog2(LOG_N + 2);
    localparam int unsigned CW = $clog2(PIPE_STAGES + 1);
    localparam int unsigned IW = 2 + 2 * LW + 2 * ADDR_W;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StFinish} state_e;

    state_e            r_state, w_state_d;
    logic [SW-1:0]     r_s, w_s_d;
    logic [ADDR_W-1:0] r_j, w_j_d;
    logic [CW-1:0]     r_drain, w_drain_d;
    logic              r_inv, w_inv_d;
    logic [IW-1:0]     r_hold;
    logic [IW:0]       r_wb [PIPE_STAGES];

    logic              w_last_stage;
    logic              w_scale;
    logic              w_issue_valid;
    logic [LW-1:0]     w_log_t;
    logic [LW-1:0]     w_log_m;
    logic [1:0]        w_phase;
    logic [ADDR_W-1:0] w_mask;
    logic [ADDR_W-1:0] w_odd;
    logic [IW-1:0]     w_iss;
    logic [IW-1:0]     w_out;
    logic [IW:0]       w_wb;

    assign w_last_stage = (r_s == (r_inv ? SW'(LOG_N) : SW'(LOG_N - 1)));
    assign w_scale      = r_inv && (r_s == SW'(LOG_N));

    always_comb begin
        w_state_d = r_state;
        w_s_d     = r_s;
        w_j_d     = r_j;
        w_drain_d = r_drain;
        w_inv_d   = r_inv;
        unique case (r_state)
            StIdle: begin
                if (i_start) begin
                    w_inv_d   = i_inverse;
                    w_s_d     = '0;
                    w_j_d     = '0;
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                if (r_j == ADDR_W'(D - 1)) begin
                    w_j_d     = '0;
                    w_drain_d = '0;
                    w_state_d = StDrain;
                end else begin
                    w_j_d = r_j + ADDR_W'(1);
                end
            end
            StDrain: begin
                if (r_drain == CW'(PIPE_STAGES - 1)) begin
                    if (w_last_stage) begin
                        w_state_d = StFinish;
                    end else begin
                        w_s_d     = r_s + SW'(1);
                        w_state_d = StIssue;
                    end
                end else begin
                    w_drain_d = r_drain + CW'(1);
                end
            end
            StFinish: w_state_d = StIdle;
            default:  w_state_d = StIdle;
        endcase
    end

    // Issue-side values for the current (s, j); forward and inverse share log_m = LOG_N-1-log_t.
    always_comb begin
        w_log_t = '0;
        w_log_m = '0;
        w_phase = 2'd2;
        if (!w_scale) begin
            w_log_t = r_inv ? LW'(r_s) : LW'(LOG_N - 1) - LW'(r_s);
            w_log_m = LW'(LOG_N - 1) - w_log_t;
            w_phase = (32'(w_log_t) >= ADDR_W) ? 2'd0 : 2'd1;
        end
        w_mask = ADDR_W'(1) << w_log_t;
        w_odd  = (w_phase == 2'd1) ? (r_j ^ w_mask) : r_j;
        w_iss  = {w_phase, w_log_m, w_log_t, r_j, w_odd};
    end

    assign w_issue_valid = (r_state == StIssue);
    assign w_out         = w_issue_valid ? w_iss : r_hold;
    assign w_wb          = r_wb[PIPE_STAGES-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_s     <= '0;
            r_j     <= '0;
            r_drain <= '0;
            r_inv   <= 1'b0;
            r_hold  <= '0;
        end else begin
            r_state <= w_state_d;
            r_s     <= w_s_d;
            r_j     <= w_j_d;
            r_drain <= w_drain_d;
            r_inv   <= w_inv_d;
            r_hold  <= w_out;
        end
    end

    // Free-running delay line, clocks in every state so wb_* is always issue-side delayed by P.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(PIPE_STAGES); i++) r_wb[i] <= '0;
        end else begin
            r_wb[0] <= {w_issue_valid, w_out};
            for (int i = 1; i < int'(PIPE_STAGES); i++) r_wb[i] <= r_wb[i-1];
        end
    end

    assign o_busy        = (r_state == StIssue) || (r_state == StDrain);
    assign o_done        = (r_state == StFinish);
    assign o_issue_valid = w_issue_valid;
    assign {o_phase, o_log_m, o_log_t, o_even_addr, o_odd_addr} = w_out;
    assign {o_wb_valid, o_wb_phase, o_wb_log_m, o_wb_log_t, o_wb_even_addr, o_wb_odd_addr} = w_wb;

endmodule

// File: tb/tb_ntt_sequencer.sv
// Scoreboard bench for ntt_sequencer: randomized runs against a stage/address reference model,
// plus a small-parameter instance for the schedule-length sweep.
module tb_ntt_sequencer;

    localparam int LOG_N  = 12;
    localparam int LCC    = 5;
    localparam int P      = 10;
    localparam int ADDR_W = LOG_N - 1 - LCC;
    localparam int D      = 1 << ADDR_W;
    localparam int LW     = 4;
    localparam int B_LW   = 3;
    localparam int B_AW   = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, inverse = 1'b0;
    logic start_b = 1'b0, inverse_b = 1'b0;

    logic              busy, done, issue_valid, wb_valid;
    logic [1:0]        phase, wb_phase;
    logic [LW-1:0]     log_m, log_t, wb_log_m, wb_log_t;
    logic [ADDR_W-1:0] even_addr, odd_addr, wb_even_addr, wb_odd_addr;

    logic              busy_b, done_b, issue_valid_b, wb_valid_b;
    logic [1:0]        phase_b, wb_phase_b;
    logic [B_LW-1:0]   log_m_b, log_t_b, wb_log_m_b, wb_log_t_b;
    logic [B_AW-1:0]   even_b, odd_b, wb_even_b, wb_odd_b;

    always #5 clk = ~clk;

    ntt_sequencer #(.LOG_N(LOG_N), .LOG_CORE_COUNT(LCC), .PIPE_STAGES(P)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_inverse(inverse),
        .o_busy(busy), .o_done(done), .o_issue_valid(issue_valid), .o_phase(phase),
        .o_log_m(log_m), .o_log_t(log_t), .o_even_addr(even_addr), .o_odd_addr(odd_addr),
        .o_wb_valid(wb_valid), .o_wb_phase(wb_phase), .o_wb_log_m(wb_log_m),
        .o_wb_log_t(wb_log_t), .o_wb_even_addr(wb_even_addr), .o_wb_odd_addr(wb_odd_addr)
    );

    ntt_sequencer #(.LOG_N(8), .LOG_CORE_COUNT(2), .PIPE_STAGES(3)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_inverse(inverse_b),
        .o_busy(busy_b), .o_done(done_b), .o_issue_valid(issue_valid_b), .o_phase(phase_b),
        .o_log_m(log_m_b), .o_log_t(log_t_b), .o_even_addr(even_b), .o_odd_addr(odd_b),
        .o_wb_valid(wb_valid_b), .o_wb_phase(wb_phase_b), .o_wb_log_m(wb_log_m_b),
        .o_wb_log_t(wb_log_t_b), .o_wb_even_addr(wb_even_b), .o_wb_odd_addr(wb_odd_b)
    );

    typedef struct {
        int iss;
        int cyc;
    } exp_t;

    exp_t sbq[$];
    int   done_q[$];
    int   hist_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_iss = 0;
    int   mon_iss;
    exp_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: per-stage exponents from the stage index, odd partner flips bit log_t when local.
    function automatic int model(input bit inv, input int s, input int j);
        int lt, lm, ph, od;
        logic [21:0] v;
        if (inv && s == LOG_N) begin
            lt = 0; lm = 0; ph = 2; od = j;
        end else begin
            lt = inv ? s : LOG_N - 1 - s;
            lm = LOG_N - 1 - lt;
            ph = (lt >= ADDR_W) ? 0 : 1;
            od = (ph == 1) ? (j ^ (1 << lt)) : j;
        end
        v = {ph[1:0], lm[3:0], lt[3:0], j[5:0], od[5:0]};
        return int'(v);
    endfunction

    task automatic push_run(input bit inv, input int t0);
        int ns;
        ns = inv ? LOG_N + 1 : LOG_N;
        for (int s = 0; s < ns; s++)
            for (int j = 0; j < D; j++)
                sbq.push_back('{iss: model(inv, s, j), cyc: t0 + s * (D + P) + 1 + j});
        done_q.push_back(t0 + ns * (D + P) + 1);
    endtask

    function automatic int iss_side();
        return int'({busy, done, issue_valid, phase, log_m, log_t, even_addr, odd_addr});
    endfunction

    function automatic int wb_side();
        return int'({wb_valid, wb_phase, wb_log_m, wb_log_t, wb_even_addr, wb_odd_addr});
    endfunction

    // Monitor: pops expectations whenever the DUT issues or completes.
    always @(negedge clk) begin
        if (!rst_n) begin
            hist_q.delete();
            repeat (P) hist_q.push_back(0);
            last_iss = 0;
        end else begin
            mon_iss = int'({phase, log_m, log_t, even_addr, odd_addr});
            if (issue_valid) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_issue", mon_iss, -1);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("issue_cycle", cyc, mon_e.cyc);
                    chk("issue_fields", mon_iss, mon_e.iss);
                end
                if (phase == 2'd1) chk("local_pair_distinct", int'(even_addr != odd_addr), 1);
                if (phase == 2'd1 && log_t == 4'd2 && even_addr == 6'd5)
                    chk("local_example_odd", int'(odd_addr), 1);
            end else begin
                chk("hold_outputs", mon_iss, last_iss);
            end
            last_iss = mon_iss;
            if (done) begin
                if (done_q.size() == 0) chk("unexpected_done", cyc, -1);
                else chk("done_cycle", cyc, done_q.pop_front());
                chk("busy_at_done", int'(busy), 0);
            end
            hist_q.push_back(int'({issue_valid, phase, log_m, log_t, even_addr, odd_addr}));
            chk("wb_align", wb_side(), hist_q.pop_front());
        end
    end

    task automatic wait_done(input bit noise);
        int n;
        n = 0;
        while (!done && n < 3000) begin
            if (noise && $urandom_range(0, 39) == 0) begin
                start = 1'b1;
                inverse = 1'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 3000) chk("done_timeout", 0, 1);
    endtask

    task automatic launch(input bit inv);
        @(negedge clk);
        start = 1'b1;
        inverse = inv;
        push_run(inv, cyc);
        @(negedge clk);
        start = 1'b0;
        inverse = 1'($urandom);
    endtask

    task automatic run_b(input bit inv, input int exp_done, input int exp_iss);
        int t0, n_iss, n_wb, k;
        n_iss = 0; n_wb = 0; k = 0;
        @(negedge clk);
        start_b = 1'b1;
        inverse_b = inv;
        t0 = cyc;
        @(negedge clk);
        start_b = 1'b0;
        inverse_b = 1'b0;
        while (!done_b && k < 2000) begin
            n_iss += int'(issue_valid_b);
            n_wb += int'(wb_valid_b);
            @(negedge clk);
            k++;
        end
        chk("b_done_cycle", cyc - t0, exp_done);
        chk("b_issue_count", n_iss, exp_iss);
        chk("b_wb_count", n_wb, exp_iss);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int t0, k, bad;
        repeat (3) @(negedge clk);
        chk("reset_issue_side", iss_side(), 0);
        chk("reset_wb_side", wb_side(), 0);
        chk("reset_b", int'({busy_b, done_b, issue_valid_b, wb_valid_b}), 0);
        rst_n = 1'b1;

        launch(1'b0);
        wait_done(1'b1);

        // Start held across FINISH: ignored there, accepted in the following IDLE cycle.
        start = 1'b1;
        inverse = 1'b1;
        @(negedge clk);
        chk("finish_start_ignored", int'({busy, issue_valid}), 0);
        push_run(1'b1, cyc);
        @(negedge clk);
        start = 1'b0;
        inverse = 1'b0;
        wait_done(1'b1);

        repeat (2) begin
            launch(1'($urandom));
            wait_done(1'b1);
        end

        launch(1'b0);
        t0 = cyc - 1;
        k = 3 * (D + P) + 1 + int'($urandom_range(0, D + P - 1));
        while (cyc - t0 < k) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_issue_side", iss_side(), 0);
        chk("async_reset_wb_side", wb_side(), 0);
        sbq.delete();
        done_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (wb_valid || issue_valid || busy) bad++;
        end
        chk("idle_after_reset", bad, 0);
        launch(1'b0);
        wait_done(1'b0);

        run_b(1'b0, 8 * 35 + 1, 8 * 32);
        run_b(1'b1, 9 * 35 + 1, 9 * 32);

        repeat (15) @(negedge clk);
        chk("scoreboard_drained", sbq.size() + done_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
